// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP host and the LBP core bench.
//   AW    : address width of the gray and LBP stores
//   DW    : pixel / LBP data width
//   DEPTH : entries per store (2**AW)
//   lbp_state_e : host sequencing states
package lbp_pkg;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } lbp_state_e;
endpackage

// File: rtl/lbp_store.sv
// DEPTH x DW store with one synchronous write port, a registered read port
// and a per-entry valid bit. Entries never written (or wiped by clear_all)
// read as zero.
//   clk, reset      : clock, synchronous active-high reset
//   clear_all       : drop every valid bit this cycle
//   we/waddr/wdata  : write port
//   re/raddr        : read enable / address; rdata holds when re=0
//   rdata           : registered read data
module lbp_store #(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_all,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid;

    // Data array has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            rdata <= '0;
        end else begin
            if (clear_all)
                valid <= '0;
            else if (we)
                valid[waddr] <= 1'b1;

            if (re) begin
                // Same-cycle write to the read address is forwarded so a
                // read issued alongside the final write sees the new value.
                if (clear_all)
                    rdata <= '0;
                else if (we && (waddr == raddr))
                    rdata <= wdata;
                else if (valid[raddr])
                    rdata <= mem[raddr];
                else
                    rdata <= '0;
            end
        end
    end
endmodule

// File: rtl/lbp_host.sv
// Host-side responder for the LBP core: loads a gray image from a stream,
// serves the core's gray reads, captures its LBP writes, then streams the
// results out once the core signals finish.
//   clk, reset                   : clock, synchronous active-high reset
//   start                        : begin a pass (honoured in IDLE / DONE)
//   load_valid/load_data/ready   : gray image input stream, raster order
//   core_start                   : one-cycle pulse on the first RUN cycle
//   gray_req/gray_addr/gray_data : core read port, 1-cycle latency
//   lbp_write/lbp_addr/lbp_data  : core write port, rising edge = one write
//   finish                       : core done
//   rd_valid/rd_data/rd_ready    : result output stream, address 0 first
//   done                         : high in DONE
//   wr_count                     : captured writes this pass, saturating
module lbp_host
    import lbp_pkg::*;
#(
    parameter int AW    = lbp_pkg::AW,
    parameter int DW    = lbp_pkg::DW,
    parameter int DEPTH = lbp_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          core_start,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_write,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic          done,
    output logic [AW:0]   wr_count
);
    lbp_state_e    state;
    logic [AW-1:0] ld_ptr;
    logic [AW-1:0] rd_ptr;
    logic          lbp_wr_q;

    logic          new_pass;
    logic          load_fire;
    logic          wr_edge;
    logic          rd_fire;
    logic          last_beat;
    logic          res_re;
    logic [AW-1:0] res_raddr;

    assign new_pass  = ((state == IDLE) || (state == DONE)) && start;
    assign load_fire = (state == LOAD) && load_valid && load_ready;
    assign wr_edge   = (state == RUN) && lbp_write && !lbp_wr_q;
    assign rd_fire   = (state == DRAIN) && rd_valid && rd_ready;
    assign last_beat = (rd_ptr == AW'(DEPTH - 1));

    // Result reads are prefetched: address 0 on the finish cycle so it is
    // on rd_data in the first DRAIN cycle, then rd_ptr+1 on each handshake.
    always_comb begin
        res_re    = 1'b0;
        res_raddr = '0;
        if ((state == RUN) && finish) begin
            res_re    = 1'b1;
            res_raddr = '0;
        end else if (rd_fire && !last_beat) begin
            res_re    = 1'b1;
            res_raddr = rd_ptr + AW'(1);
        end
    end

    lbp_store #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_gray (
        .clk       (clk),
        .reset     (reset),
        .clear_all (1'b0),
        .we        (load_fire),
        .waddr     (ld_ptr),
        .wdata     (load_data),
        .re        ((state == RUN) && gray_req),
        .raddr     (gray_addr),
        .rdata     (gray_data)
    );

    lbp_store #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_result (
        .clk       (clk),
        .reset     (reset),
        .clear_all (new_pass),
        .we        (wr_edge),
        .waddr     (lbp_addr),
        .wdata     (lbp_data),
        .re        (res_re),
        .raddr     (res_raddr),
        .rdata     (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            load_ready <= 1'b0;
            core_start <= 1'b0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            wr_count   <= '0;
            ld_ptr     <= '0;
            rd_ptr     <= '0;
            lbp_wr_q   <= 1'b0;
        end else begin
            // Tracks lbp_write in every state so a level already high on
            // entry to RUN is not mistaken for a fresh write.
            lbp_wr_q   <= lbp_write;
            core_start <= 1'b0;

            if (wr_edge && (wr_count != {(AW+1){1'b1}}))
                wr_count <= wr_count + (AW+1)'(1);

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        load_ready <= 1'b1;
                        done       <= 1'b0;
                        ld_ptr     <= '0;
                        wr_count   <= '0;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        ld_ptr <= ld_ptr + AW'(1);
                        if (ld_ptr == AW'(DEPTH - 1)) begin
                            state      <= RUN;
                            load_ready <= 1'b0;
                            core_start <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (finish) begin
                        state    <= DRAIN;
                        rd_valid <= 1'b1;
                        rd_ptr   <= '0;
                    end
                end
                DRAIN: begin
                    if (rd_fire) begin
                        if (last_beat) begin
                            state    <= DONE;
                            rd_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lbp_host.sv
module tb_lbp_host;
    import lbp_pkg::*;

    logic          clk = 1'b0;
    logic          reset, start, load_valid, gray_req, lbp_write, finish, rd_ready;
    logic [DW-1:0] load_data, lbp_data;
    logic [AW-1:0] gray_addr, lbp_addr;
    logic          load_ready, core_start, rd_valid, done;
    logic [DW-1:0] gray_data, rd_data;
    logic [AW:0]   wr_count;

    int checks = 0;
    int errors = 0;

    lbp_host dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .core_start(core_start),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .lbp_write(lbp_write), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
        .finish(finish),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .done(done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are observed and inputs changed 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start then a full 64-beat load; reverse=1 loads 0x3F..0x00.
    task automatic do_load(input bit reverse);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1;
            load_data  = reverse ? 8'(63 - i) : 8'(i);
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; load_valid = 1'b1; load_data = 8'hFF;
        gray_req = 1'b0; gray_addr = '0; lbp_write = 1'b0; lbp_addr = '0;
        lbp_data = '0; finish = 1'b0; rd_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
        checks++; if (gray_data !== 8'h00) begin errors++; $display("FAIL reset_gray_data got=%h exp=00", gray_data); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd got=%b/%h exp=0/00", rd_valid, rd_data); end
        checks++; if (done !== 1'b0 || wr_count !== 7'd0) begin errors++; $display("FAIL reset_done_cnt got=%b/%0d exp=0/0", done, wr_count); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
        load_valid = 1'b0;
    endtask

    task automatic test_load();
        int ready_cycles = 0;
        int pulses = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i);
            if (load_ready === 1'b1) ready_cycles++;
            if (core_start === 1'b1) pulses++;
            tick();
        end
        load_valid = 1'b0;
        if (core_start === 1'b1) pulses++;
        checks++; if (ready_cycles != 64) begin errors++; $display("FAIL load_ready_cycles got=%0d exp=64", ready_cycles); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_after got=%b exp=0", load_ready); end
        checks++; if (dut.state !== RUN) begin errors++; $display("FAIL load_state got=%0d exp=%0d", dut.state, RUN); end
        tick();
        if (core_start === 1'b1) pulses++;
        checks++; if (pulses != 1) begin errors++; $display("FAIL core_start_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_gray_read();
        gray_req = 1'b1; gray_addr = 6'h3F;
        tick();
        checks++; if (gray_data !== 8'h3F) begin errors++; $display("FAIL gray_rd_3f got=%h exp=3f", gray_data); end
        gray_addr = 6'h2A;
        tick();
        checks++; if (gray_data !== 8'h2A) begin errors++; $display("FAIL gray_rd_2a got=%h exp=2a", gray_data); end
        gray_req = 1'b0; gray_addr = 6'h05;
        tick(); tick();
        checks++; if (gray_data !== 8'h2A) begin errors++; $display("FAIL gray_hold got=%h exp=2a", gray_data); end
        // start is ignored while running
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (dut.state !== RUN || load_ready !== 1'b0) begin errors++; $display("FAIL start_in_run state=%0d ready=%b exp=%0d/0", dut.state, load_ready, RUN); end
    endtask

    task automatic test_lbp_write();
        lbp_write = 1'b1; lbp_addr = 6'd9; lbp_data = 8'h5C;
        tick();
        lbp_write = 1'b0;
        tick();
        checks++; if (wr_count !== 7'd1) begin errors++; $display("FAIL wr_count_1 got=%0d exp=1", wr_count); end
        lbp_write = 1'b1; lbp_data = 8'h11;
        tick();
        lbp_write = 1'b0;
        tick();
        lbp_write = 1'b1; lbp_addr = 6'd3; lbp_data = 8'h77;
        tick(); tick(); tick();
        lbp_write = 1'b0;
        tick();
        checks++; if (wr_count !== 7'd3) begin errors++; $display("FAIL wr_count_3 got=%0d exp=3", wr_count); end
    endtask

    task automatic test_finish_drain();
        logic [DW-1:0] exp_res [DEPTH];
        int beat = 0;
        int cyc  = 0;
        for (int i = 0; i < DEPTH; i++) exp_res[i] = 8'h00;
        exp_res[9] = 8'h11; exp_res[3] = 8'h77; exp_res[62] = 8'hEE;
        lbp_write = 1'b1; lbp_addr = 6'd62; lbp_data = 8'hEE; finish = 1'b1;
        tick();
        lbp_write = 1'b0; finish = 1'b0;
        checks++; if (wr_count !== 7'd4) begin errors++; $display("FAIL finish_wr_count got=%0d exp=4", wr_count); end
        checks++; if (rd_valid !== 1'b1 || dut.state !== DRAIN) begin errors++; $display("FAIL drain_entry rd_valid=%b state=%0d exp=1/%0d", rd_valid, dut.state, DRAIN); end
        while (beat < DEPTH && cyc < 1000) begin
            rd_ready = (cyc % 3 == 0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_res[beat]) begin
                errors++;
                $display("FAIL drain_beat%0d cyc%0d got=%b/%h exp=1/%h", beat, cyc, rd_valid, rd_data, exp_res[beat]);
            end
            tick();
            if (rd_ready) beat++;
            cyc++;
        end
        rd_ready = 1'b0;
        checks++; if (beat != DEPTH) begin errors++; $display("FAIL drain_timeout beats=%0d exp=64", beat); end
        checks++; if (rd_valid !== 1'b0 || done !== 1'b1 || dut.state !== DONE) begin errors++; $display("FAIL drain_end rd_valid=%b done=%b state=%0d exp=0/1/%0d", rd_valid, done, dut.state, DONE); end
    endtask

    task automatic test_reset_mid_load();
        int beat = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            load_valid = 1'b1; load_data = 8'(8'hA0 + i);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0 || done !== 1'b0 || gray_data !== 8'h00 || rd_valid !== 1'b0) begin errors++; $display("FAIL midload_reset ready=%b done=%b gray=%h rdv=%b exp=0/0/00/0", load_ready, done, gray_data, rd_valid); end
        checks++; if (dut.state !== IDLE || wr_count !== 7'd0) begin errors++; $display("FAIL midload_state state=%0d cnt=%0d exp=%0d/0", dut.state, wr_count, IDLE); end
        do_load(1'b1);
        checks++; if (core_start !== 1'b1 || dut.state !== RUN) begin errors++; $display("FAIL reload_run core_start=%b state=%0d exp=1/%0d", core_start, dut.state, RUN); end
        gray_req = 1'b1; gray_addr = 6'h00;
        tick();
        checks++; if (gray_data !== 8'h3F) begin errors++; $display("FAIL reload_gray0 got=%h exp=3f", gray_data); end
        gray_addr = 6'h10;
        tick();
        gray_req = 1'b0;
        checks++; if (gray_data !== 8'h2F) begin errors++; $display("FAIL reload_gray10 got=%h exp=2f", gray_data); end
        lbp_write = 1'b1; lbp_addr = 6'd0; lbp_data = 8'h42;
        tick();
        lbp_write = 1'b0; finish = 1'b1;
        tick();
        finish = 1'b0; rd_ready = 1'b1;
        while (beat < DEPTH && rd_valid === 1'b1) begin
            checks++;
            if (rd_data !== ((beat == 0) ? 8'h42 : 8'h00)) begin
                errors++;
                $display("FAIL reload_beat%0d got=%h exp=%h", beat, rd_data, (beat == 0) ? 8'h42 : 8'h00);
            end
            tick();
            beat++;
        end
        rd_ready = 1'b0;
        checks++; if (beat != DEPTH || done !== 1'b1 || wr_count !== 7'd1) begin errors++; $display("FAIL reload_end beats=%0d done=%b cnt=%0d exp=64/1/1", beat, done, wr_count); end
    endtask

    task automatic test_restart_empty();
        int beat = 0;
        int zeros = 0;
        do_load(1'b0);
        checks++; if (wr_count !== 7'd0 || done !== 1'b0) begin errors++; $display("FAIL restart_clear cnt=%0d done=%b exp=0/0", wr_count, done); end
        finish = 1'b1;
        tick();
        finish = 1'b0; rd_ready = 1'b1;
        while (beat < DEPTH && rd_valid === 1'b1) begin
            if (rd_data === 8'h00) zeros++;
            tick();
            beat++;
        end
        rd_ready = 1'b0;
        checks++; if (zeros != DEPTH || beat != DEPTH) begin errors++; $display("FAIL restart_zeros zeros=%0d beats=%0d exp=64/64", zeros, beat); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done got=%b exp=1", done); end
    endtask

    task automatic test_saturate();
        do_load(1'b0);
        for (int i = 0; i < 130; i++) begin
            lbp_write = 1'b1; lbp_addr = 6'(i); lbp_data = 8'(i);
            tick();
            lbp_write = 1'b0;
            tick();
        end
        checks++; if (wr_count !== 7'd127) begin errors++; $display("FAIL wr_count_sat got=%0d exp=127", wr_count); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_gray_read();
        test_lbp_write();
        test_finish_drain();
        test_reset_mid_load();
        test_restart_empty();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lbp_host.md
Name: lbp_host

Overview:
Host-side responder for the LBP core's gray/lbp interface.
- Holds a 64-entry gray image loaded over a valid/ready stream.
- Serves the core's gray_req/gray_addr reads and captures its lbp_write results into a result store.
- Once the core raises finish, streams the 64 LBP bytes out over a valid/ready port.
- This is the synthesizable counterpart to the gray-image and LBP-result memories the core talks to, so a full image pass runs without the bench.

Parameters:
AW, 6, address width of gray and LBP stores
DW, 8, pixel / LBP data width
DEPTH, 64, entries per store (must equal 2**AW)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a new image pass (sampled in IDLE and DONE only)
load_valid  in  1  load beat present
load_data  in  DW  gray pixel, raster order, address 0 first
load_ready  out  1  host accepts load beat
core_start  out  1  one-cycle pulse: image loaded, core may run
gray_req  in  1  core read request
gray_addr  in  AW  core read address
gray_data  out  DW  registered read data
lbp_write  in  1  core write strobe (level; rising edge = one write)
lbp_addr  in  AW  write address
lbp_data  in  DW  write data
finish  in  1  core done
rd_valid  out  1  result beat present
rd_data  out  DW  LBP result, address 0 first
rd_ready  in  1  downstream accepts result beat
done  out  1  high in DONE
wr_count  out  AW+1  lbp_write edges captured this pass (saturates at 2**(AW+1)-1)

Behaviour:
- Reset values: load_ready=0, core_start=0, gray_data=0, rd_valid=0, rd_data=0, done=0, wr_count=0; state=IDLE; all result-valid bits cleared; internal lbp_write delay flop=0.
- FSM states:
  - IDLE: start=1 -> LOAD.
  - LOAD: load_ready=1. Each load_valid&load_ready writes gray[ld_ptr], then ld_ptr++. Accepting beat DEPTH-1 -> RUN next cycle; core_start=1 for exactly that first RUN cycle.
  - RUN: serve reads and capture writes. finish=1 -> DRAIN.
  - DRAIN: stream addresses 0..DEPTH-1. Handshake on the beat at address DEPTH-1 -> DONE.
  - DONE: done=1. start=1 -> LOAD.
- Entering LOAD, from IDLE or DONE: ld_ptr=0, wr_count=0, all result-valid bits cleared in that same cycle. Gray contents are overwritten by the new load, not cleared.
- Gray read, RUN only: gray_req=1 at edge N -> gray_data = gray[gray_addr] after edge N, i.e. 1-cycle latency. gray_req=0 or state!=RUN -> gray_data holds its value.
- LBP write, RUN only:
  - Detect the rising edge: lbp_write=1 and previous-cycle lbp_write=0.
  - On an edge: result[lbp_addr]=lbp_data, valid[lbp_addr]=1, wr_count++.
  - A level held high counts once.
  - A repeat write to the same address: last value wins, and it counts again.
- Result read: an entry whose valid bit is 0 reads as 0.
- DRAIN output: rd_valid=1 from the first DRAIN cycle. rd_data is registered and presents result[rd_ptr]. Under rd_ready=0, rd_valid and rd_data are held stable. rd_ptr advances only on handshake. rd_valid drops the cycle after the final handshake.
- Simultaneous lbp_write edge and finish in RUN: the write is captured, then the FSM enters DRAIN.
- Ignored events:
  - load_valid outside LOAD (load_ready=0, data dropped).
  - gray_req and lbp_write outside RUN.
  - finish outside RUN.
  - start in LOAD, RUN or DRAIN.
- Reset mid-operation: immediate return to IDLE with all reset values; a partial load or drain is abandoned.
- Storage: two DEPTH x DW arrays with a single write port each; inferable as registers or RAM. The valid vector is a DEPTH-bit register.

Decomposition:
- Shared package lbp_pkg: AW/DW/DEPTH constants and the state enum (IDLE, LOAD, RUN, DRAIN, DONE), reused by the LBP core bench.
- One natural sub-module, lbp_store: a DEPTH x DW array with synchronous write, registered read, a per-entry valid bit, a clear_all input and zero-on-invalid read. Instantiate it twice; the gray instance ties clear_all=0.

Test Plan:
- Reset, then start; load 64 beats of values 0x00..0x3F with load_valid held -> load_ready high for 64 cycles; core_start pulses once; state RUN.
- RUN, gray_req=1, gray_addr=0x2A -> gray_data=0x2A one cycle later; deassert gray_req -> gray_data holds 0x2A.
- lbp_write pulses: addr 9 data 0x5C; addr 9 data 0x11; lbp_write held high 3 cycles at addr 3 data 0x77 -> wr_count=3; result[9]=0x11; result[3]=0x77.
- finish=1 in the same cycle as an lbp_write edge at addr 62 data 0xEE; drain with rd_ready toggling 1,0,0,1,... -> 64 beats, data stable while stalled, beat 62=0xEE, beat 9=0x11, unwritten beats=0x00; done=1 after beat 63.
- Assert reset mid-load after 20 beats -> all outputs at reset values, state IDLE; a fresh start and full load succeeds.
- From DONE, start again -> wr_count=0; drain with no writes returns 64 zeros.
